button_event_decoder: RTL and testbench



---
 rtl/button_event_decoder_pkg.sv | 27 ++
 rtl/button_event_decoder_if.sv | 24 ++
 rtl/button_event_decoder_evt_slot.sv | 41 ++++
 rtl/button_event_decoder.sv | 104 ++++++++++
 tb/tb_button_event_decoder.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/button_event_decoder_pkg.sv
// Shared event codes and FSM state encodings for the button event decoder
// and its downstream consumers.
package button_event_decoder_pkg;

  typedef enum logic [1:0] {
    EVT_NONE   = 2'b00,
    EVT_SHORT  = 2'b01,
    EVT_LONG   = 2'b10,
    EVT_DOUBLE = 2'b11
  } evt_code_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRESS1    = 3'd1,
    ST_LONG_HELD = 3'd2,
    ST_GAP       = 3'd3,
    ST_PRESS2    = 3'd4
  } state_t;

  // Timer must hold the larger of the two timeouts without wrapping.
  function automatic int timer_width(input int long_time, input int dclick_time);
    int m;
    m = (long_time > dclick_time) ? long_time : dclick_time;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/button_event_decoder_if.sv
// Valid/ready event channel from the button decoder to its consumer.
interface button_event_decoder_if;
  import button_event_decoder_pkg::*;

  logic      evt_valid;
  logic      evt_ready;
  evt_code_t evt_code;
  logic      evt_drop;

  modport master (
    output evt_valid,
    output evt_code,
    output evt_drop,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_code,
    input  evt_drop,
    output evt_ready
  );

endinterface

// File: rtl/button_event_decoder_evt_slot.sv
// Single-entry valid/ready holding register; a new event arriving while the
// slot is stalled is discarded and flagged on drop for one cycle.
module evt_slot
  import button_event_decoder_pkg::*;
(
  input  logic      aclk,
  input  logic      srst,
  input  logic      emit,
  input  evt_code_t emit_code,
  input  logic      ready,
  output logic      valid,
  output evt_code_t code,
  output logic      drop
);

  logic      valid_reg;
  evt_code_t code_reg;
  logic      drop_reg;

  always_ff @(posedge aclk) begin
    if (srst) begin
      valid_reg <= 1'b0;
      code_reg  <= EVT_NONE;
      drop_reg  <= 1'b0;
    end else begin
      drop_reg <= emit & valid_reg & ~ready;
      if (emit && (!valid_reg || ready)) begin
        valid_reg <= 1'b1;
        code_reg  <= emit_code;
      end else if (valid_reg && ready) begin
        valid_reg <= 1'b0;
        code_reg  <= EVT_NONE;
      end
    end
  end

  assign valid = valid_reg;
  assign code  = code_reg;
  assign drop  = drop_reg;

endmodule

// File: rtl/button_event_decoder.sv
// Classifies debounced button gestures into SHORT, LONG and DOUBLE events and
// presents them through a single-entry valid/ready slot.
module button_event_decoder
  import button_event_decoder_pkg::*;
#(
  parameter int LONG_TIME   = 1000,
  parameter int DCLICK_TIME = 300
) (
  input  logic                   aclk,
  input  logic                   srst,
  input  logic                   button,
  button_event_decoder_if.master evt
);

  localparam int TW = timer_width(LONG_TIME, DCLICK_TIME);
  localparam logic [TW-1:0] LONG_LAST   = TW'(LONG_TIME - 1);
  localparam logic [TW-1:0] DCLICK_LAST = TW'(DCLICK_TIME - 1);
  localparam logic [TW-1:0] TIMER_MAX   = '1;

  logic          btn_q;
  state_t        state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic          rise, fall;
  logic          emit;
  evt_code_t     emit_code;

  assign rise = button & ~btn_q;
  assign fall = ~button & btn_q;

  // btn_q resets high so a button held through reset produces no rise.
  always_ff @(posedge aclk) begin
    if (srst) begin
      btn_q     <= 1'b1;
      state_reg <= ST_IDLE;
      timer_reg <= '0;
    end else begin
      btn_q     <= button;
      state_reg <= state_next;
      timer_reg <= timer_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    emit       = 1'b0;
    emit_code  = EVT_NONE;
    case (state_reg)
      ST_IDLE: begin
        if (rise) state_next = ST_PRESS1;
      end
      ST_PRESS1: begin
        if (fall) begin
          state_next = ST_GAP;
        end else if (timer_reg == LONG_LAST) begin
          emit       = 1'b1;
          emit_code  = EVT_LONG;
          state_next = ST_LONG_HELD;
        end
      end
      ST_LONG_HELD: begin
        if (fall) state_next = ST_IDLE;
      end
      ST_GAP: begin
        // A rise on the expiry cycle still counts as the second click.
        if (rise) begin
          state_next = ST_PRESS2;
        end else if (timer_reg == DCLICK_LAST) begin
          emit       = 1'b1;
          emit_code  = EVT_SHORT;
          state_next = ST_IDLE;
        end
      end
      ST_PRESS2: begin
        if (fall) begin
          emit       = 1'b1;
          emit_code  = EVT_DOUBLE;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    timer_next = timer_reg;
    if (state_next != state_reg) begin
      timer_next = '0;
    end else if ((state_reg == ST_PRESS1 || state_reg == ST_GAP) && timer_reg != TIMER_MAX) begin
      timer_next = timer_reg + 1'b1;
    end
  end

  evt_slot u_slot (
    .aclk      (aclk),
    .srst      (srst),
    .emit      (emit),
    .emit_code (emit_code),
    .ready     (evt.evt_ready),
    .valid     (evt.evt_valid),
    .code      (evt.evt_code),
    .drop      (evt.evt_drop)
  );

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with LONG_TIME=20, DCLICK_TIME=8:
// a gesture vector table plus hand-written backpressure and reset sequences.
module tb_button_event_decoder;
  import button_event_decoder_pkg::*;

  logic aclk = 1'b0;
  logic srst;
  logic button;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  button_event_decoder_if evt_if ();

  button_event_decoder #(
    .LONG_TIME   (20),
    .DCLICK_TIME (8)
  ) dut (
    .aclk   (aclk),
    .srst   (srst),
    .button (button),
    .evt    (evt_if)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct {
    int code;
    int t;
  } ev_t;
  ev_t log_q[$];

  // Every accepted event, stamped with the cycle number it became visible.
  always @(negedge aclk) begin
    if (evt_if.evt_valid && evt_if.evt_ready) log_q.push_back('{int'(evt_if.evt_code), cyc});
  end

  typedef struct {
    int p1;    // first press cycles
    int g;     // released cycles after first press
    int p2;    // second press cycles (0 = none)
    int tail;  // released cycles after second press
    int n;     // expected event count
    int c0;
    int t0;    // expected visible cycle, relative to vector start
    int c1;
    int t1;
  } vec_t;

  vec_t vecs[9];

  task automatic step(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vector(input int idx);
    int c0;
    vec_t v;
    v = vecs[idx];
    log_q.delete();
    c0 = cyc;
    button = 1'b1;
    step(v.p1);
    button = 1'b0;
    step(v.g);
    if (v.p2 > 0) begin
      button = 1'b1;
      step(v.p2);
      button = 1'b0;
      step(v.tail);
    end
    step(3);
    check($sformatf("vec%0d count", idx), log_q.size(), v.n);
    if (v.n >= 1 && log_q.size() >= 1) begin
      check($sformatf("vec%0d ev0 code", idx), log_q[0].code, v.c0);
      check($sformatf("vec%0d ev0 time", idx), log_q[0].t - c0, v.t0);
    end
    if (v.n >= 2 && log_q.size() >= 2) begin
      check($sformatf("vec%0d ev1 code", idx), log_q[1].code, v.c1);
      check($sformatf("vec%0d ev1 time", idx), log_q[1].t - c0, v.t1);
    end
    $display("vector %0d: p1=%0d g=%0d p2=%0d events=%0d", idx, v.p1, v.g, v.p2, log_q.size());
  endtask

  initial begin
    int hold_bad;
    int drop_n;
    int drop_at;

    vecs[0] = '{5, 20, 0, 0, 1, 1, 14, 0, 0};   // short press
    vecs[1] = '{30, 20, 0, 0, 1, 2, 21, 0, 0};  // long hold, silent release
    vecs[2] = '{3, 4, 3, 20, 1, 3, 11, 0, 0};   // double click
    vecs[3] = '{3, 8, 3, 20, 1, 3, 15, 0, 0};   // rise on the gap expiry cycle
    vecs[4] = '{3, 9, 3, 20, 2, 1, 12, 1, 24};  // gap just too long: two shorts
    vecs[5] = '{19, 20, 0, 0, 1, 1, 28, 0, 0};  // release well before long
    vecs[6] = '{20, 20, 0, 0, 1, 1, 29, 0, 0};  // fall beats long expiry
    vecs[7] = '{21, 20, 0, 0, 1, 2, 21, 0, 0};  // shortest long
    vecs[8] = '{3, 4, 40, 20, 1, 3, 48, 0, 0};  // long second press still double

    // Reset with button held: no edge afterwards.
    srst = 1'b1;
    button = 1'b1;
    evt_if.evt_ready = 1'b1;
    step(3);
    check("reset valid", int'(evt_if.evt_valid), 0);
    check("reset code", int'(evt_if.evt_code), 0);
    check("reset drop", int'(evt_if.evt_drop), 0);
    log_q.delete();
    srst = 1'b0;
    step(5);
    button = 1'b0;
    step(15);
    check("held through reset events", log_q.size(), 0);
    $display("startup: held through reset, events=%0d", log_q.size());

    for (int i = 0; i < 9; i++) run_vector(i);

    // Backpressure: first SHORT held, second one dropped.
    evt_if.evt_ready = 1'b0;
    button = 1'b1;
    step(3);
    button = 1'b0;
    step(20);
    check("stall first valid", int'(evt_if.evt_valid), 1);
    check("stall first code", int'(evt_if.evt_code), int'(EVT_SHORT));
    hold_bad = 0;
    drop_n = 0;
    drop_at = 0;
    for (int k = 1; k <= 23; k++) begin
      button = (k <= 3);
      step(1);
      if (!evt_if.evt_valid || evt_if.evt_code != EVT_SHORT) hold_bad++;
      if (evt_if.evt_drop) begin
        drop_n++;
        drop_at = k;
      end
    end
    check("stall hold stable", hold_bad, 0);
    check("stall drop count", drop_n, 1);
    check("stall drop cycle", drop_at, 12);
    $display("backpressure: drops=%0d at %0d", drop_n, drop_at);

    // Ready rises on the LONG emit cycle: new event replaces the old one.
    button = 1'b1;
    step(20);
    evt_if.evt_ready = 1'b1;
    step(1);
    check("replace valid", int'(evt_if.evt_valid), 1);
    check("replace code", int'(evt_if.evt_code), int'(EVT_LONG));
    check("replace drop", int'(evt_if.evt_drop), 0);
    step(1);
    check("drain valid", int'(evt_if.evt_valid), 0);
    check("drain code", int'(evt_if.evt_code), int'(EVT_NONE));
    log_q.delete();
    button = 1'b0;
    step(20);
    check("long release events", log_q.size(), 0);
    $display("replace: long loaded on accept, release events=%0d", log_q.size());

    // Reset while an event is pending: event lost.
    evt_if.evt_ready = 1'b0;
    button = 1'b1;
    step(3);
    button = 1'b0;
    step(15);
    check("pending before reset", int'(evt_if.evt_valid), 1);
    srst = 1'b1;
    step(1);
    srst = 1'b0;
    check("pending after reset valid", int'(evt_if.evt_valid), 0);
    check("pending after reset code", int'(evt_if.evt_code), 0);
    evt_if.evt_ready = 1'b1;
    $display("reset with pending event: valid=%0d", evt_if.evt_valid);

    // Reset mid-PRESS1 with button kept high: gesture abandoned.
    step(5);
    log_q.delete();
    button = 1'b1;
    step(5);
    srst = 1'b1;
    step(1);
    srst = 1'b0;
    step(40);
    button = 1'b0;
    step(10);
    check("mid-press reset events", log_q.size(), 0);
    $display("reset mid-press: events=%0d", log_q.size());
    run_vector(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
